// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: registered IDLE/SETUP/ACCESS/DONE sequencer for one RAM word transfer
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req,
    input  logic        we,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [8:0]  mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [8:0]  mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    // Next state and next registered outputs; address/data hold unless a request is latched
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        ready_d       = 1'b0;
        done_d        = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req && ready_q) begin
                    state_d       = SETUP;
                    ready_d       = 1'b0;
                    we_d          = we;
                    mem_address_d = addr;
                    mem_wdata_d   = wdata;
                end
            end
            SETUP: begin
                state_d     = ACCESS;
                cnt_d       = 4'(WAIT_CYCLES);
                mem_read_d  = !we_q;
                mem_write_d = we_q;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = we_q ? rdata_q : mem_rdata;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                    mem_read_d  = !we_q;
                    mem_write_d = we_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            we_q          <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 9'd0;
            mem_wdata_q   <= 32'd0;
            rdata_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized bench with a transaction-timeline reference model
module tb_mem_access_ctrl;
    localparam int W = 1;
    localparam int DONE_K = W + 3;

    logic        clock = 1'b0;
    logic        clear, req, we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        ready, done, mem_read, mem_write;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [8:0]  mem_address;

    logic        req0, we0;
    logic [8:0]  addr0;
    logic [31:0] wdata0;
    logic        ready0, done0, mem_read0, mem_write0;
    logic [31:0] rdata0, mem_wdata0, mem_rdata0;
    logic [8:0]  mem_address0;

    logic [31:0] ram [512];
    logic [31:0] ram0 [512];
    logic [31:0] ram_m [512];

    int checks = 0, errors = 0, cyc = 0;
    bit busy = 0, acc = 0, m_we = 0;
    int k = 0, gap = 0, last_acc = 0, n = 0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
        .clock(clock), .clear(clear), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clock(clock), .clear(clear), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .done(done0), .rdata(rdata0), .mem_read(mem_read0), .mem_write(mem_write0),
        .mem_address(mem_address0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    // RAM model: combinational read while strobed, write on any edge with the write strobe high
    assign mem_rdata  = mem_read  ? ram[mem_address]   : '0;
    assign mem_rdata0 = mem_read0 ? ram0[mem_address0] : '0;

    always @(posedge clock) begin
        if (mem_write) ram[mem_address] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: advance the model by the transaction rules, then compare every output
    task automatic tick();
        bit strobe;
        @(posedge clock);
        cyc++;
        acc = 0;
        if (busy && m_we && k >= 2 && k <= W + 2) ram_m[m_addr] = m_wdata;
        if (!clear) begin
            busy = 0;
            k = 0;
            m_rdata = '0;
        end else if (busy) begin
            if (k == DONE_K) busy = 0;
            else begin
                k++;
                if (k == DONE_K && !m_we) m_rdata = ram_m[m_addr];
            end
        end else if (req) begin
            busy = 1;
            k = 1;
            acc = 1;
            m_we = we;
            m_addr = addr;
            m_wdata = wdata;
            gap = cyc - last_acc;
            last_acc = cyc;
        end
        #1;
        strobe = busy && k >= 2 && k <= W + 2;
        chk("ready", ready, !busy);
        chk("done", done, busy && k == DONE_K);
        chk("mem_read", mem_read, strobe && !m_we);
        chk("mem_write", mem_write, strobe && m_we);
        chk("rdata", rdata, m_rdata);
        if (busy) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic wait_idle();
        req = 0;
        clear = 1;
        for (int i = 0; i < 10 && busy; i++) tick();
    endtask

    // Transfer with addr/wdata/we scrambled every cycle after acceptance
    task automatic xfer(input bit w, input logic [8:0] a, input logic [31:0] d);
        wait_idle();
        req = 1;
        we = w;
        addr = a;
        wdata = d;
        tick();
        chk("xfer_acc", acc, 1);
        req = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            addr = 9'($urandom);
            wdata = $urandom;
            we = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram[i] <= v;
            ram_m[i] = v;
            ram0[i] <= 32'(i) ^ 32'h5A5A_0000;
        end
        ram[5] <= 32'hDEAD_BEEF;
        ram_m[5] = 32'hDEAD_BEEF;
        ram0[0] <= 32'hA5A5_0001;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        clear = 0; req = 1; we = 0; addr = 9'h005; wdata = 32'hCAFE_F00D;
        tick();
        tick();
        chk("rst_address", mem_address, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ready", ready, 1);
        clear = 1;
        tick();
        chk("first_acc", acc, 1);
        req = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            addr = 9'($urandom);
            wdata = $urandom;
            tick();
        end
        chk("rd5", rdata, 32'hDEAD_BEEF);

        xfer(1, 9'h1FF, 32'h1234_5678);
        chk("wr_keeps_rdata", rdata, 32'hDEAD_BEEF);
        xfer(0, 9'h1FF, 32'h0);
        chk("rd1ff", rdata, 32'h1234_5678);

        wait_idle();
        req = 1;
        we = 0;
        addr = 9'h010;
        n = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            tick();
            if (acc) begin
                n++;
                if (n > 1) chk("gap", gap, W + 4);
                we = ~we;
            end
        end
        chk("held_n", n, 3);

        wait_idle();
        req = 1; we = 0; addr = 9'h003;
        tick();
        req = 0;
        tick();
        tick();
        clear = 0;
        tick();
        chk("abort_read", mem_read, 0);
        chk("abort_done", done, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_ready", ready, 1);
        clear = 1;
        tick();
        chk("abort_no_done", done, 0);

        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 39) != 0);
            req = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
            wdata = $urandom;
            tick();
        end

        wait_idle();
        chk("w0_ready", ready0, 1);
        req0 = 1; we0 = 0; addr0 = 9'h000;
        tick();
        req0 = 0;
        addr0 = 9'h1AA;
        chk("w0_setup_read", mem_read0, 0);
        chk("w0_setup_ready", ready0, 0);
        chk("w0_setup_addr", mem_address0, 0);
        tick();
        chk("w0_strobe", mem_read0, 1);
        chk("w0_nowrite", mem_write0, 0);
        chk("w0_early_done", done0, 0);
        tick();
        chk("w0_strobe_off", mem_read0, 0);
        chk("w0_done", done0, 1);
        chk("w0_rdata", rdata0, 32'hA5A5_0001);
        tick();
        chk("w0_done_off", done0, 0);
        chk("w0_idle", ready0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, default 1, extra cycles the RAM strobe is held beyond the first (legal 0..15).
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: clear  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 SHALL have port: req  input  1  datapath request to start one memory transfer.
REQ-005 SHALL have port: we  input  1  transfer direction; 1 = write, 0 = read; sampled with req.
REQ-006 SHALL have port: addr  input  9  word address; sampled with req.
REQ-007 SHALL have port: wdata  input  32  write data; sampled with req.
REQ-008 SHALL have port: ready  output  1  controller idle and able to accept req.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking transfer completion.
REQ-010 SHALL have port: rdata  output  32  registered data from the last completed read.
REQ-011 SHALL have port: mem_read  output  1  RAM read strobe.
REQ-012 SHALL have port: mem_write  output  1  RAM write strobe.
REQ-013 SHALL have port: mem_address  output  9  RAM word address.
REQ-014 SHALL have port: mem_wdata  output  32  data driven onto the RAM write-data bus (BusMuxOut).
REQ-015 SHALL have port: mem_rdata  input  32  RAM read-data bus (Mdatain); high-impedance when RAM not reading.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE; every state and output is registered.
REQ-017 SHALL drive ready = 1 only in IDLE; req is accepted only on an edge where req && ready.
REQ-018 SHALL, on acceptance, latch we, addr and wdata, then go IDLE -> SETUP.
REQ-019 SHALL, in SETUP: drive mem_address = latched addr and mem_wdata = latched wdata, both strobes 0, for exactly one cycle, then go SETUP -> ACCESS.
REQ-020 SHALL, in ACCESS, assert mem_read (we=0) or mem_write (we=1) for exactly WAIT_CYCLES+1 consecutive cycles, counted by an internal 4-bit counter loaded at SETUP.
REQ-021 SHALL never assert mem_read and mem_write in the same cycle.
REQ-022 SHALL hold mem_address and mem_wdata constant from SETUP through DONE inclusive; mem_wdata is don't-care on reads but still held.
REQ-023 SHALL, for a read, load rdata from mem_rdata on the rising edge that ends the final ACCESS cycle, and only then; rdata SHALL NOT change on writes or in any other cycle.
REQ-024 SHALL go ACCESS -> DONE after the final ACCESS cycle; in DONE both strobes are 0 and done = 1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-025 SHALL assert done in cycle T+WAIT_CYCLES+3, where T is the acceptance cycle (WAIT_CYCLES=1: T+4).
REQ-026 SHALL ignore req (and we/addr/wdata changes) in SETUP, ACCESS and DONE; a held req is accepted in the first IDLE cycle after DONE, so the minimum spacing between back-to-back acceptances is WAIT_CYCLES+4 cycles.
REQ-027 SHALL accept WAIT_CYCLES=0 (single-cycle strobe, done at T+3).

Reset
REQ-028 SHALL, on any edge with clear = 0, enter IDLE and set ready=1, done=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, rdata=0, and clear the counter.
REQ-029 SHALL, when clear = 0 during SETUP/ACCESS/DONE, abandon the transfer: strobes low from the next cycle, no rdata capture, no done pulse.
REQ-030 SHALL give clear priority over a concurrent req; the first acceptance is possible on the first edge with clear = 1.

Verification
REQ-031 SHALL be verified: reset, then read req addr=9'h005, RAM word 5 = 32'hDEADBEEF, WAIT_CYCLES=1 -> mem_read high cycles T+2..T+3, done at T+4, rdata=32'hDEADBEEF.
REQ-032 SHALL be verified: write req addr=9'h1FF, wdata=32'h12345678 -> mem_write high two cycles with mem_address=9'h1FF; subsequent read of 9'h1FF returns 32'h12345678; rdata unchanged by the write.
REQ-033 SHALL be verified: req held high continuously with alternating we -> acceptances exactly 5 cycles apart, ready low in between, strobes never overlap.
REQ-034 SHALL be verified: clear=0 in second ACCESS cycle of a read -> strobes 0 next cycle, no done, rdata=0, ready=1.
REQ-035 SHALL be verified: WAIT_CYCLES=0, read addr=9'h000 -> mem_read high one cycle (T+2), done at T+3.
REQ-036 SHALL be verified: addr/wdata toggled every cycle after acceptance -> mem_address and mem_wdata stay at latched values until DONE ends.
